// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to count 0..w-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder used as the per-cycle stage of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one result bit per RUN cycle, result registered on completion.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-2:0] part_q;
    logic [WIDTH-1:0] part_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_sum, fa_carry;
    logic             accept, running, last;

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign accept    = (state_q == ST_IDLE) && start;
    assign running   = (state_q == ST_RUN);
    assign last      = (cnt_q == CW'(WIDTH - 1));
    // New bit enters at the MSB; on the last cycle this is the complete result.
    assign part_next = {fa_sum, part_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= '0;
                carry_q <= cin;
            end else if (running) begin
                cnt_q   <= cnt_q + CW'(1);
                carry_q <= fa_carry;
                if (last) begin
                    sum_q  <= part_next;
                    cout_q <= fa_carry;
                end
            end
        end
    end

    // Operand shifters and partial result carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end else if (running) begin
            a_q    <= a_q >> 1;
            b_q    <= b_q >> 1;
            part_q <= part_next[WIDTH-1:1];
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (running && last) begin
            ovf_q <= (a_msb_q == b_msb_q) && (fa_sum != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = running;
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] prev_sum;
    logic       prev_cout;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        bit         scramble;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after DONE (back in IDLE).
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          input bit scramble, input logic [7:0] es, input logic ec,
                          input logic eo, input string tag);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " done_run"}, {31'd0, done}, 32'd0);
            chk({tag, " sum_held"}, {23'd0, cout, sum}, {23'd0, prev_cout, prev_sum});
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); cin = ~cin; start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " done"}, {30'd0, busy, done}, 32'd1);
        chk({tag, " sum"}, {24'd0, sum}, {24'd0, es});
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("unexpected x in ovf expectation");
`endif
        @(negedge clk);
        chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
        if (scramble) begin
            @(negedge clk);
            chk({tag, " no_requeue"}, {30'd0, busy, done}, 32'd0);
        end
        prev_sum  = es;
        prev_cout = ec;
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0};
        vecs[6] = '{8'hC8, 8'h9C, 1'b0, 1'b1, 8'h64, 1'b1, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_flags", {30'd0, busy, done}, 32'd0);
        chk("reset_result", {23'd0, cout, sum}, 32'd0);
        rst = 1'b0; start = 1'b0;
        prev_sum = 8'h00; prev_cout = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].scramble,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));

        // Abort mid-RUN: reset lands on the 4th RUN cycle.
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "pre_abort");
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("abort_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_flags", {30'd0, busy, done}, 32'd0);
        chk("abort_result", {23'd0, cout, sum}, 32'd0);
        rst = 1'b0;
        prev_sum = 8'h00; prev_cout = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "post_abort");

        // start held high: each result uses operands present at acceptance, period WIDTH+2.
        begin
            logic [7:0] oa[3] = '{8'h10, 8'hF0, 8'h99};
            logic [7:0] ob[3] = '{8'h22, 8'h20, 8'h99};
            logic       oc[3] = '{1'b1, 1'b0, 1'b1};
            logic [8:0] full;
            int n;
            a = oa[0]; b = ob[0]; cin = oc[0]; start = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk($sformatf("hold%0d accept", k), {31'd0, busy}, 32'd1);
                full = {1'b0, oa[k]} + {1'b0, ob[k]} + {8'd0, oc[k]};
                a = 8'($urandom); b = 8'($urandom); cin = ~cin;
                n = 0;
                while (!done && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                chk($sformatf("hold%0d latency", k), n, 32'd8);
                chk($sformatf("hold%0d result", k), {23'd0, cout, sum}, {23'd0, full});
                @(negedge clk);
                chk($sformatf("hold%0d idle", k), {30'd0, busy, done}, 32'd0);
                if (k < 2) begin
                    a = oa[k+1]; b = ob[k+1]; cin = oc[k+1];
                end
            end
            start = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
